// File: rtl/wb_regfile.sv
// wb_regfile -- write-back stage and 8 x 16 architectural register file.
//
// The selected result (ALU, memory, load-immediate, link PC) is captured into
// a one-entry write-back register and committed to the array on the following
// edge. Two independent combinational read ports bypass the pending write so
// a result is visible to readers from the edge it is captured.
//
// Ports:
//   clk, rst_n         clock (rising edge), asynchronous active-low reset
//   wb_valid           instruction writes a register
//   wb_sel             result source: 0 ALU, 1 mem, 2 load-immediate, 3 link
//   wb_rd              destination register
//   alu_result, mem_rdata, li_value, link_pc   candidate results
//   stall              ignore this cycle's inputs (bubble into write-back)
//   ra1/ra2, rd1/rd2   read addresses / read data (R0 reads zero)
//   pend_valid/pend_rd write-back register status
//   write_count        committed register writes, wraps at 16 bits
module wb_regfile #(
   parameter int DATA_W = 16,
   parameter int NREG   = 8,
   parameter int ADDR_W = 3
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              wb_valid,
   input  logic [1:0]        wb_sel,
   input  logic [ADDR_W-1:0] wb_rd,
   input  logic [DATA_W-1:0] alu_result,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic [DATA_W-1:0] li_value,
   input  logic [DATA_W-1:0] link_pc,
   input  logic              stall,
   input  logic [ADDR_W-1:0] ra1,
   input  logic [ADDR_W-1:0] ra2,
   output logic [DATA_W-1:0] rd1,
   output logic [DATA_W-1:0] rd2,
   output logic              pend_valid,
   output logic [ADDR_W-1:0] pend_rd,
   output logic [15:0]       write_count
);

   logic [DATA_W-1:0] regs_q [NREG];

   logic              pend_valid_q, pend_valid_d;
   logic [ADDR_W-1:0] pend_rd_q,    pend_rd_d;
   logic [DATA_W-1:0] pend_data_q,  pend_data_d;
   logic [15:0]       write_count_q, write_count_d;
   logic [DATA_W-1:0] wb_mux;

   always_comb begin
      wb_mux = alu_result;
      unique case (wb_sel)
         2'b00: wb_mux = alu_result;
         2'b01: wb_mux = mem_rdata;
         2'b10: wb_mux = li_value;
         2'b11: wb_mux = link_pc;
      endcase
   end

   // Stall inserts a bubble; rd/data hold so a stalled instruction is only
   // taken once, on the first non-stall edge. Writes to R0 never go pending.
   always_comb begin
      pend_valid_d  = 1'b0;
      pend_rd_d     = pend_rd_q;
      pend_data_d   = pend_data_q;
      write_count_d = write_count_q;
      if (!stall) begin
         pend_valid_d = wb_valid && (wb_rd != '0);
         pend_rd_d    = wb_rd;
         pend_data_d  = wb_mux;
      end
      if (pend_valid_q) begin
         write_count_d = write_count_q + 16'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend_valid_q  <= 1'b0;
         pend_rd_q     <= '0;
         pend_data_q   <= '0;
         write_count_q <= '0;
      end else begin
         pend_valid_q  <= pend_valid_d;
         pend_rd_q     <= pend_rd_d;
         pend_data_q   <= pend_data_d;
         write_count_q <= write_count_d;
      end
   end

   // Commit uses the old pending entry; a same-edge capture to the same
   // register lands in the write-back register and wins through the bypass.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < NREG; i++) begin
            regs_q[i] <= '0;
         end
      end else if (pend_valid_q) begin
         regs_q[pend_rd_q] <= pend_data_q;
      end
   end

   always_comb begin
      rd1 = regs_q[ra1];
      if (ra1 == '0) begin
         rd1 = '0;
      end else if (pend_valid_q && (pend_rd_q == ra1)) begin
         rd1 = pend_data_q;
      end
   end

   always_comb begin
      rd2 = regs_q[ra2];
      if (ra2 == '0) begin
         rd2 = '0;
      end else if (pend_valid_q && (pend_rd_q == ra2)) begin
         rd2 = pend_data_q;
      end
   end

   assign pend_valid  = pend_valid_q;
   assign pend_rd     = pend_rd_q;
   assign write_count = write_count_q;

endmodule

// File: tb/tb_wb_regfile.sv
// tb_wb_regfile -- directed and randomized bench for wb_regfile.
//
// The reference model tracks the architectural view a reader sees: the value
// most recently accepted for each register (pending or committed), plus the
// write-back status and a count of accepted writes that have since committed.
module tb_wb_regfile;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        wb_valid = 1'b0;
   logic [1:0]  wb_sel = '0;
   logic [2:0]  wb_rd = '0;
   logic [15:0] alu_result = '0;
   logic [15:0] mem_rdata = '0;
   logic [15:0] li_value = '0;
   logic [15:0] link_pc = '0;
   logic        stall = 1'b0;
   logic [2:0]  ra1 = '0;
   logic [2:0]  ra2 = '0;
   logic [15:0] rd1, rd2;
   logic        pend_valid;
   logic [2:0]  pend_rd;
   logic [15:0] write_count;

   wb_regfile #(.DATA_W(16), .NREG(8), .ADDR_W(3)) dut (
      .clk(clk), .rst_n(rst_n), .wb_valid(wb_valid), .wb_sel(wb_sel),
      .wb_rd(wb_rd), .alu_result(alu_result), .mem_rdata(mem_rdata),
      .li_value(li_value), .link_pc(link_pc), .stall(stall),
      .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
      .pend_valid(pend_valid), .pend_rd(pend_rd), .write_count(write_count)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   bit started  = 1'b0;

   // ---------------- reference model ----------------
   logic [15:0] view [8];
   bit          m_pv;
   logic [2:0]  m_prd;
   logic [15:0] m_cnt;

   task automatic model_reset();
      for (int i = 0; i < 8; i++) view[i] = '0;
      m_pv  = 1'b0;
      m_prd = '0;
      m_cnt = '0;
   endtask

   task automatic model_edge();
      logic [15:0] src [4];
      src[0] = alu_result;
      src[1] = mem_rdata;
      src[2] = li_value;
      src[3] = link_pc;
      if (m_pv) m_cnt = m_cnt + 16'd1;
      if (stall) begin
         m_pv = 1'b0;
      end else begin
         m_pv  = wb_valid && (wb_rd != 3'd0);
         m_prd = wb_rd;
         if (m_pv) view[wb_rd] = src[wb_sel];
      end
   endtask

   function automatic logic [15:0] exp_rd(input logic [2:0] a);
      return (a == 3'd0) ? 16'h0000 : view[a];
   endfunction

   initial model_reset();
   always @(negedge rst_n) model_reset();
   always @(posedge clk) if (rst_n) model_edge();

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Per-cycle comparison against the model.
   always @(negedge clk) begin
      if (started) begin
         chk("rd1", {16'h0, rd1}, {16'h0, exp_rd(ra1)});
         chk("rd2", {16'h0, rd2}, {16'h0, exp_rd(ra2)});
         chk("pend_valid", {31'h0, pend_valid}, {31'h0, m_pv});
         if (m_pv) chk("pend_rd", {29'h0, pend_rd}, {29'h0, m_prd});
         chk("write_count", {16'h0, write_count}, {16'h0, m_cnt});
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic put(input logic v, input logic [1:0] s, input logic [2:0] rd,
                      input logic [15:0] d);
      wb_valid   = v;
      wb_sel     = s;
      wb_rd      = rd;
      alu_result = (s == 2'd0) ? d : 16'h0BAD;
      mem_rdata  = (s == 2'd1) ? d : 16'h0BAD;
      li_value   = (s == 2'd2) ? d : 16'h0BAD;
      link_pc    = (s == 2'd3) ? d : 16'h0BAD;
   endtask

   initial begin
      #2 rst_n = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      #1 rst_n = 1'b1;
      started = 1'b1;

      // Reset state: every address on both ports reads zero.
      for (int i = 0; i < 8; i++) begin
         ra1 = 3'(i);
         ra2 = 3'(7 - i);
         #1;
         chk("reset_rd1", {16'h0, rd1}, 32'h0);
         chk("reset_rd2", {16'h0, rd2}, 32'h0);
      end
      chk("reset_count", {16'h0, write_count}, 32'h0);
      chk("reset_pend", {31'h0, pend_valid}, 32'h0);

      // LHI then LLI on R3: bypass composes the old Rt value.
      ra2 = 3'd3;
      put(1'b1, 2'd2, 3'd3, 16'hAB00);
      step();
      chk("lhi_bypass", {16'h0, rd2}, 32'hAB00);
      chk("lhi_pend_rd", {29'h0, pend_rd}, 32'd3);
      put(1'b1, 2'd2, 3'd3, 16'hAB5C);
      step();
      chk("lli_bypass", {16'h0, rd2}, 32'hAB5C);
      chk("lli_count1", {16'h0, write_count}, 32'd1);
      wb_valid = 1'b0;
      step();
      chk("lli_commit", {16'h0, rd2}, 32'hAB5C);
      chk("lli_count2", {16'h0, write_count}, 32'd2);

      // Write to R0 is dropped.
      ra1 = 3'd0;
      put(1'b1, 2'd0, 3'd0, 16'h1234);
      step();
      chk("r0_pend", {31'h0, pend_valid}, 32'h0);
      chk("r0_read", {16'h0, rd1}, 32'h0);
      wb_valid = 1'b0;
      step();
      chk("r0_count", {16'h0, write_count}, 32'd2);

      // Stall: R5 commits, held R6 write is dropped as a bubble.
      ra1 = 3'd5;
      ra2 = 3'd6;
      put(1'b1, 2'd0, 3'd5, 16'h00FF);
      step();
      put(1'b1, 2'd1, 3'd6, 16'h7777);
      stall = 1'b1;
      step();
      chk("stall_pend", {31'h0, pend_valid}, 32'h0);
      chk("stall_count", {16'h0, write_count}, 32'd3);
      chk("stall_r5", {16'h0, rd1}, 32'h00FF);
      chk("stall_r6", {16'h0, rd2}, 32'h0);
      stall = 1'b0;
      wb_valid = 1'b0;
      step();
      chk("stall_r6_after", {16'h0, rd2}, 32'h0);
      chk("stall_count_after", {16'h0, write_count}, 32'd3);

      // Reset mid-operation discards the pending R2 write.
      ra1 = 3'd2;
      put(1'b1, 2'd3, 3'd2, 16'hBEEF);
      step();
      chk("rst_pend_before", {31'h0, pend_valid}, 32'h1);
      chk("rst_bypass_before", {16'h0, rd1}, 32'hBEEF);
      wb_valid = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      chk("rst_pend_async", {31'h0, pend_valid}, 32'h0);
      chk("rst_count_async", {16'h0, write_count}, 32'h0);
      @(negedge clk);
      #1 rst_n = 1'b1;
      step();
      chk("rst_r2", {16'h0, rd1}, 32'h0);
      chk("rst_count", {16'h0, write_count}, 32'h0);

      // Counter wrap: 65535 writes to R1, then one more.
      ra1 = 3'd1;
      for (int i = 0; i < 65535; i++) begin
         put(1'b1, 2'(i % 4), 3'd1, 16'(i));
         step();
      end
      wb_valid = 1'b0;
      step();
      chk("cnt_ffff", {16'h0, write_count}, 32'hFFFF);
      chk("cnt_r1", {16'h0, rd1}, 32'hFFFE);
      put(1'b1, 2'd1, 3'd1, 16'hC0DE);
      step();
      wb_valid = 1'b0;
      step();
      chk("cnt_wrap", {16'h0, write_count}, 32'h0000);
      chk("cnt_r1_last", {16'h0, rd1}, 32'hC0DE);

      // Randomized traffic, including stalls and occasional async reset.
      for (int c = 0; c < 3000; c++) begin
         stall      = ($urandom_range(0, 3) == 0);
         wb_valid   = ($urandom_range(0, 3) != 0);
         wb_sel     = 2'($urandom_range(0, 3));
         wb_rd      = 3'($urandom_range(0, 7));
         alu_result = 16'($urandom);
         mem_rdata  = 16'($urandom);
         li_value   = 16'($urandom);
         link_pc    = 16'($urandom);
         ra1        = 3'($urandom_range(0, 7));
         ra2        = ($urandom_range(0, 3) == 0) ? ra1 : 3'($urandom_range(0, 7));
         if ($urandom_range(0, 399) == 0) begin
            #2 rst_n = 1'b0;
            @(negedge clk);
            #1 rst_n = 1'b1;
         end
         step();
      end

      wb_valid = 1'b0;
      stall = 1'b0;
      repeat (2) step();
      started = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/wb_regfile.md
Name: wb_regfile

Overview:
- Write-back stage plus architectural register file for the 16-bit CPU.
- Selects the result source (ALU, memory, load-immediate value, link PC) and holds it for one cycle in a write-back register, then commits it to an 8 x 16 register file.
- Provides two combinational read ports with bypass from the pending write. Read port 2 supplies the old Rt value that the load-immediate helper needs, so a back-to-back LHI followed by LLI on the same register composes correctly.

Parameters:
DATA_W, 16, register/data width
NREG, 8, number of architectural registers (R0 hardwired to zero)
ADDR_W, 3, register address width (log2 NREG)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
wb_valid  in  1  current instruction writes a register
wb_sel  in  2  result source: 00 ALU, 01 mem, 10 load-immediate, 11 link
wb_rd  in  ADDR_W  destination register
alu_result  in  DATA_W  ALU output
mem_rdata  in  DATA_W  data memory read data
li_value  in  DATA_W  load-immediate helper output
link_pc  in  DATA_W  return address (PC+2)
stall  in  1  pipeline stall; inputs this cycle are ignored
ra1  in  ADDR_W  read address, port 1 (Rs)
ra2  in  ADDR_W  read address, port 2 (Rt)
rd1  out  DATA_W  read data, port 1
rd2  out  DATA_W  read data, port 2
pend_valid  out  1  write-back register holds an uncommitted write
pend_rd  out  ADDR_W  destination of the pending write
write_count  out  16  number of committed register writes

Behaviour:
- Reset (rst_n low, asynchronous):
  - all registers = 0
  - pend_valid = 0, pend_rd = 0, pending data = 0
  - write_count = 0
  - rd1/rd2 then read 0
  - Reset may assert mid-operation; any pending write is discarded, not committed.
- Source mux (combinational): selects one of the four sources per wb_sel.
- Capture, at each rising edge:
  - If stall = 0: pend_valid <= wb_valid & (wb_rd != 0); pend_rd <= wb_rd; pend_data <= mux output.
  - If stall = 1: pend_valid <= 0, inserting a bubble. The held upstream instruction is captured on the first non-stall edge, so it is never written twice.
- Commit, at the same rising edge: if pend_valid = 1, reg[pend_rd] <= pend_data and write_count increments. Commit happens regardless of stall. Total latency is 2 edges from inputs to the array.
- write_count wraps from 0xFFFF to 0x0000. Writes addressed to R0 never become pending and are not counted.
- Reads (combinational, each port independent):
  - ra == 0 -> 0.
  - Else if pend_valid and pend_rd == ra -> pend_data (bypass).
  - Else reg[ra].
- Capture and commit on the same edge to the same register: the commit writes the older value and the pending register takes the newer one. Reads then return the newer value through the bypass.
- Both ports reading the same address return identical data.
- No write-through from the wb_* inputs themselves. The upstream stage must not depend on same-cycle results.

Test Plan:
- Reset, then read all 8 addresses on both ports -> all 0; write_count = 0; pend_valid = 0.
- Edge 1: wb_sel=10, li_value=0xAB00, wb_rd=3, valid. Edge 2: li_value=0xAB5C, rd=3. Check ra2=3 -> rd2=0xAB00 after edge 1 (bypass). After edge 2, array R3=0xAB00 and rd2=0xAB5C. After edge 3, R3=0xAB5C and write_count=2.
- wb_rd=0, wb_sel=00, alu_result=0x1234, valid -> pend_valid stays 0; rd1(ra1=0)=0; write_count unchanged.
- Pending write to R5=0x00FF with stall=1 on the next edge and inputs R6=0x7777 -> R5 commits, R6 is never written, pend_valid=0 afterwards, write_count=+1.
- Preload write_count to 0xFFFF with 65535 writes (R1 alternating sources), one more write -> write_count=0x0000.
- Pending write R2=0xBEEF, assert rst_n low between edges -> pend_valid drops immediately; R2 reads 0 after release; write_count=0.
